// File: rtl/scan_mux_if.sv
// Channel-select bus between the lane sources and the scan multiplexer.
// Handshake: the consumer side (master) drives en/mode/sel/data_in each cycle;
// the multiplexer (slave) returns a registered sample, and valid=1 marks the
// one cycle in which data_out/ch_out carry a fresh sample.
// wrap pulses for one cycle with the first channel-0 sample of a new scan lap.
interface scan_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1
);
    localparam int SELW = $clog2(N_CH);

    logic                  en;
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [N_CH*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]      data_out;
    logic [SELW-1:0]       ch_out;
    logic                  valid;
    logic                  wrap;

    modport master (
        output en, mode, sel, data_in,
        input  data_out, ch_out, valid, wrap
    );

    modport slave (
        input  en, mode, sel, data_in,
        output data_out, ch_out, valid, wrap
    );
endinterface

// File: rtl/scan_mux_seq.sv
// Registered N-channel multiplexer with manual select and an auto-scan mode
// that holds each channel for DWELL cycles before stepping to the next one.
// fsm_state exposes the controller state (0=IDLE, 1=MANUAL, 2=SCAN).
module scan_mux_seq #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 1,
    parameter  int DWELL = 4,
    localparam int SELW  = $clog2(N_CH)
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_mux_if.slave  bus,
    output logic [1:0] fsm_state
);
    localparam int              CNTW     = $clog2(DWELL + 1);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(N_CH - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    // Remembers that the last active state was SCAN, so a freeze in IDLE
    // resumes the scan instead of reloading the start channel.
    logic            armed_q, armed_d;

    logic [WIDTH-1:0] data_d;
    logic [SELW-1:0]  ch_d;
    logic             valid_d, wrap_d;

    logic             sel_ok;
    logic             resume;
    logic [SELW-1:0]  start_ptr;
    logic [SELW-1:0]  step_ptr;
    logic [CNTW-1:0]  step_cnt;
    logic             step_wrap;

    function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] lanes,
                                              input logic [SELW-1:0]       idx);
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SELW'(k)) pick = lanes[k*WIDTH +: WIDTH];
        end
    endfunction

    assign fsm_state = state_q;

    // Scan stepping: next pointer/dwell count and wrap detection.
    always_comb begin
        sel_ok    = (int'(bus.sel) < N_CH);
        start_ptr = sel_ok ? bus.sel : '0;
        resume    = (state_q == SCAN) || ((state_q == IDLE) && armed_q);
        step_ptr  = ptr_q;
        step_cnt  = cnt_q + CNTW'(1);
        step_wrap = 1'b0;
        if (cnt_q == CNT_LAST) begin
            step_cnt = '0;
            if (ptr_q == LAST_CH) begin
                step_ptr  = '0;
                step_wrap = 1'b1;
            end else begin
                step_ptr = ptr_q + SELW'(1);
            end
        end
    end

    // Next-state and next-output decode; a disabled block holds everything.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        data_d  = bus.data_out;
        ch_d    = bus.ch_out;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
        end else if (!bus.mode) begin
            state_d = MANUAL;
            armed_d = 1'b0;
            ch_d    = bus.sel;
            data_d  = sel_ok ? pick(bus.data_in, bus.sel) : '0;
            valid_d = sel_ok;
        end else begin
            state_d = SCAN;
            armed_d = 1'b1;
            valid_d = 1'b1;
            if (resume) begin
                ptr_d  = step_ptr;
                cnt_d  = step_cnt;
                ch_d   = step_ptr;
                data_d = pick(bus.data_in, step_ptr);
                wrap_d = step_wrap;
            end else begin
                ptr_d  = start_ptr;
                cnt_d  = '0;
                ch_d   = start_ptr;
                data_d = pick(bus.data_in, start_ptr);
            end
        end
    end

    // State, pointer, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            bus.data_out <= '0;
            bus.ch_out   <= '0;
            bus.valid    <= 1'b0;
            bus.wrap     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            bus.data_out <= data_d;
            bus.ch_out   <= ch_d;
            bus.valid    <= valid_d;
            bus.wrap     <= wrap_d;
        end
    end
endmodule

// File: tb/tb_scan_mux_seq.sv
// Bench for scan_mux_seq: a 4-channel and a 3-channel instance, 8-bit lanes,
// three-cycle dwell. Expected samples are queued as {data, ch, valid, wrap}.
module tb_scan_mux_seq;
    localparam int W  = 8;
    localparam int EW = W + 2 + 1 + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_mux_if #(.N_CH(4), .WIDTH(W)) bus4 ();
    scan_mux_if #(.N_CH(3), .WIDTH(W)) bus3 ();
    logic [1:0] st4, st3;

    scan_mux_seq #(.N_CH(4), .WIDTH(W), .DWELL(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .fsm_state(st4)
    );
    scan_mux_seq #(.N_CH(3), .WIDTH(W), .DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .fsm_state(st3)
    );

    logic [EW-1:0] obs4, obs3;
    assign obs4 = {bus4.data_out, bus4.ch_out, bus4.valid, bus4.wrap};
    assign obs3 = {bus3.data_out, bus3.ch_out, bus3.valid, bus3.wrap};

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] pack(input logic [7:0] d, input logic [1:0] c,
                                           input logic v, input logic w);
        return {d, c, v, w};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs4 !== '0) begin n_bad++; $display("FAIL reset_out4 got=%h exp=0", obs4); end
        n_cmp++;
        if (obs3 !== '0) begin n_bad++; $display("FAIL reset_out3 got=%h exp=0", obs3); end
        n_cmp++;
        if (st4 !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", st4); end
        rst_n = 1'b1;
        exp_q.push_back('0);
        tick();
        n_cmp++;
        if (obs4 !== exp_q[0]) begin n_bad++; $display("FAIL idle_after_reset got=%h exp=%h", obs4, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_manual();
        logic [EW-1:0] e;
        logic [31:0]   d;
        int            s;
        bus4.en = 1'b1; bus4.mode = 1'b0; bus4.sel = 2'd2;
        exp_q.push_back(pack(8'h22, 2'd2, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL manual_sel2 got=%h exp=%h", obs4, e); end
        bus4.sel = 2'd3;
        exp_q.push_back(pack(8'h33, 2'd3, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL manual_sel3 got=%h exp=%h", obs4, e); end
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            s = $urandom_range(0, 3);
            bus4.data_in = d;
            bus4.sel     = 2'(s);
            exp_q.push_back(pack(d[s*8 +: 8], 2'(s), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL manual_rand%0d got=%h exp=%h", i, obs4, e); end
        end
        bus4.data_in = 32'h3322_1100;
    endtask

    task automatic test_scan_wrap();
        int            chs[12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
        logic [EW-1:0] e;
        bus4.mode = 1'b1; bus4.sel = 2'd1;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(pack(8'(chs[i] * 17), 2'(chs[i]), 1'b1, i == 9));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL scan_wrap%0d got=%h exp=%h", i, obs4, e); end
        end
    endtask

    task automatic test_freeze();
        int            chs[5] = '{2, 3, 3, 3, 0};
        logic [EW-1:0] e;
        bus4.mode = 1'b0; bus4.sel = 2'd2;
        exp_q.push_back(pack(8'h22, 2'd2, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL freeze_setup got=%h exp=%h", obs4, e); end
        bus4.mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pack(8'h22, 2'd2, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL freeze_pre%0d got=%h exp=%h", i, obs4, e); end
        end
        bus4.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pack(8'h22, 2'd2, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, obs4, e); end
        end
        n_cmp++;
        if (st4 !== 2'd0) begin n_bad++; $display("FAIL freeze_state got=%0d exp=0", st4); end
        bus4.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pack(8'(chs[i] * 17), 2'(chs[i]), 1'b1, i == 4));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL freeze_resume%0d got=%h exp=%h", i, obs4, e); end
        end
    endtask

    task automatic test_mode_priority();
        logic [EW-1:0] e;
        bus4.mode = 1'b0; bus4.sel = 2'd3;
        exp_q.push_back(pack(8'h33, 2'd3, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL prio_setup got=%h exp=%h", obs4, e); end
        bus4.mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pack(8'h33, 2'd3, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL prio_scan%0d got=%h exp=%h", i, obs4, e); end
        end
        bus4.mode = 1'b0; bus4.sel = 2'd0;
        exp_q.push_back(pack(8'h00, 2'd0, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL prio_manual got=%h exp=%h", obs4, e); end
        bus4.mode = 1'b1; bus4.sel = 2'd1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pack(8'h11, 2'd1, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL prio_rescan%0d got=%h exp=%h", i, obs4, e); end
        end
    endtask

    task automatic test_non_pow2();
        int            sels[3] = '{3, 1, 3};
        int            chs[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
        logic [EW-1:0] e;
        bus3.data_in = 24'h22_1100;
        bus3.en = 1'b1; bus3.mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus3.sel = 2'(sels[i]);
            if (sels[i] == 3) exp_q.push_back(pack(8'h00, 2'd3, 1'b0, 1'b0));
            else              exp_q.push_back(pack(8'(sels[i] * 17), 2'(sels[i]), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs3 !== e) begin n_bad++; $display("FAIL np2_manual%0d got=%h exp=%h", i, obs3, e); end
        end
        bus3.mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(pack(8'(chs[i] * 17), 2'(chs[i]), 1'b1, i == 9));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs3 !== e) begin n_bad++; $display("FAIL np2_scan%0d got=%h exp=%h", i, obs3, e); end
        end
        bus3.en = 1'b0;
    endtask

    task automatic test_async_reset();
        int            chs[4] = '{2, 2, 2, 3};
        logic [EW-1:0] e;
        bus4.mode = 1'b0; bus4.sel = 2'd3;
        exp_q.push_back(pack(8'h33, 2'd3, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL areset_setup got=%h exp=%h", obs4, e); end
        bus4.mode = 1'b1;
        exp_q.push_back(pack(8'h33, 2'd3, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (obs4 !== e) begin n_bad++; $display("FAIL areset_scan got=%h exp=%h", obs4, e); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs4 !== '0) begin n_bad++; $display("FAIL areset_immediate got=%h exp=0", obs4); end
        n_cmp++;
        if (st4 !== 2'd0) begin n_bad++; $display("FAIL areset_state got=%0d exp=0", st4); end
        tick();
        rst_n = 1'b1;
        bus4.en = 1'b1; bus4.mode = 1'b1; bus4.sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pack(8'(chs[i] * 17), 2'(chs[i]), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (obs4 !== e) begin n_bad++; $display("FAIL areset_restart%0d got=%h exp=%h", i, obs4, e); end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus4.en      = 1'b0; bus4.mode = 1'b0; bus4.sel = '0;
        bus4.data_in = 32'h3322_1100;
        bus3.en      = 1'b0; bus3.mode = 1'b0; bus3.sel = '0;
        bus3.data_in = 24'h22_1100;
        test_reset();
        test_manual();
        test_scan_wrap();
        test_freeze();
        test_mode_priority();
        test_non_pow2();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
